mem_arbiter: RTL and testbench

Arbitrates the single shared main-memory port between the instruction-cache fill FSM and the data-cache (fill and write-through) side. Sits between the two cache controllers and the multi-cycle memory. It grants exclusive ownership per transaction, muxes address, data and control to memory, and steers returning read data to the current owner only. Ownership cannot change while reads are in flight.

---
 rtl/mem_arb_pkg.sv | 25 ++
 rtl/mem_arb_pend_cnt.sv | 46 ++++
 rtl/mem_arbiter.sv | 135 +++++++++++++
 tb/tb_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_arb_pkg                                            |
// | Description : Shared types and default widths for the main-memory   |
// |               arbiter (state and owner enumerations).                |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
package mem_arb_pkg;

   localparam int DEFAULT_ADDR_W = 16;
   localparam int DEFAULT_DATA_W = 16;

   typedef enum logic [1:0] {
      ARB_IDLE    = 2'd0,
      ARB_GRANT_I = 2'd1,
      ARB_GRANT_D = 2'd2
   } arb_state_t;

   typedef enum logic [0:0] {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } arb_owner_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_pend_cnt.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_arb_pend_cnt                                       |
// | Description : Saturating up/down count of reads in flight to memory. |
// |               issue_rdy drops when MAX_OUT reads are outstanding;    |
// |               returns with nothing pending are ignored.              |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module mem_arb_pend_cnt #(
   parameter int MAX_OUT = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic inc,
   input  logic dec,
   output logic pending,
   output logic issue_rdy
);

   localparam int CNT_W = $clog2(MAX_OUT + 1);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(MAX_OUT);
   localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

   logic [CNT_W-1:0] count;
   logic             do_inc;
   logic             do_dec;

   // A return with an empty counter is stray and must not underflow.
   assign do_inc    = inc & (count != FULL);
   assign do_dec    = dec & (count != '0);
   assign pending   = (count != '0);
   assign issue_rdy = (count != FULL);

   // Count moves only when exactly one of issue/return happens.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (do_inc && !do_dec) begin
         count <= count + ONE;
      end else if (do_dec && !do_inc) begin
         count <= count - ONE;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : mem_arbiter                                            |
// | Description : Grants the shared memory port to the I-cache or the    |
// |               D-cache per transaction, muxes requests to memory and  |
// |               steers read returns to the owner. Ownership is held    |
// |               until the owner releases and all reads have returned.  |
// |               Build option: MEM_ARB_RR_EN selects round-robin on     |
// |               simultaneous requests (default: D-side wins ties).     |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W  = DEFAULT_ADDR_W,
   parameter int DATA_W  = DEFAULT_DATA_W,
   parameter int MAX_OUT = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_req,
   input  logic              i_en,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_grant,
   output logic              i_data_valid,
   input  logic              d_req,
   input  logic              d_en,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_grant,
   output logic              d_data_valid,
   output logic [DATA_W-1:0] rd_data,
   output logic              issue_rdy,
   output logic              mem_en,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              mem_data_valid
);

   arb_state_t state;
   arb_state_t state_nxt;
   arb_state_t tie_winner;
   logic       pending;

   // Writes complete at issue, so only reads are tracked.
   mem_arb_pend_cnt #(
      .MAX_OUT   (MAX_OUT)
   ) u_pend_cnt (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (mem_en & ~mem_wr),
      .dec       (mem_data_valid),
      .pending   (pending),
      .issue_rdy (issue_rdy)
   );

`ifdef MEM_ARB_RR_EN
   arb_owner_t last_owner;

   // Remember who was granted last so a tie goes to the other side.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_owner <= OWN_I;
      end else if (state == ARB_IDLE && state_nxt != ARB_IDLE) begin
         last_owner <= (state_nxt == ARB_GRANT_D) ? OWN_D : OWN_I;
      end
   end

   assign tie_winner = (last_owner == OWN_I) ? ARB_GRANT_D : ARB_GRANT_I;
`else
   assign tie_winner = ARB_GRANT_D;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ARB_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Grant from idle only; release needs req low and nothing in flight.
   always_comb begin
      state_nxt = state;
      case (state)
         ARB_IDLE: begin
            if (i_req && d_req) begin
               state_nxt = tie_winner;
            end else if (d_req) begin
               state_nxt = ARB_GRANT_D;
            end else if (i_req) begin
               state_nxt = ARB_GRANT_I;
            end
         end
         ARB_GRANT_I: if (!i_req && !pending) state_nxt = ARB_IDLE;
         ARB_GRANT_D: if (!d_req && !pending) state_nxt = ARB_IDLE;
         default:     state_nxt = ARB_IDLE;
      endcase
   end

   // Decode grants and route only the owner's access to memory.
   always_comb begin
      i_grant   = 1'b0;
      d_grant   = 1'b0;
      mem_en    = 1'b0;
      mem_wr    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         ARB_GRANT_I: begin
            i_grant  = 1'b1;
            mem_en   = i_en & issue_rdy;
            mem_addr = i_addr;
         end
         ARB_GRANT_D: begin
            d_grant   = 1'b1;
            mem_en    = d_en & issue_rdy;
            mem_wr    = d_wr;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
         end
         default: ;
      endcase
   end

   assign rd_data      = mem_data;
   assign i_data_valid = mem_data_valid & pending & i_grant;
   assign d_data_valid = mem_data_valid & pending & d_grant;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_mem_arbiter                                         |
// | Description : Directed scenarios followed by random traffic from two |
// |               requesters and a variable-latency memory, compared     |
// |               every cycle with a transaction-level reference model.  |
// | Revision    : 1.0  initial release                                   |
// +----------------------------------------------------------------------+
module tb_mem_arbiter;

   localparam int ADDR_W  = 16;
   localparam int DATA_W  = 16;
   localparam int MAX_OUT = 4;
   localparam int OWN_NONE = 0;
   localparam int OWN_IS   = 1;
   localparam int OWN_DS   = 2;

   logic              clk;
   logic              rst_n;
   logic              i_req, i_en, i_grant, i_data_valid;
   logic [ADDR_W-1:0] i_addr;
   logic              d_req, d_en, d_wr, d_grant, d_data_valid;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] rd_data;
   logic              issue_rdy, mem_en, mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_data;
   logic              mem_data_valid;

   mem_arbiter #(
      .ADDR_W (ADDR_W), .DATA_W (DATA_W), .MAX_OUT (MAX_OUT)
   ) dut (
      .clk (clk), .rst_n (rst_n),
      .i_req (i_req), .i_en (i_en), .i_addr (i_addr),
      .i_grant (i_grant), .i_data_valid (i_data_valid),
      .d_req (d_req), .d_en (d_en), .d_wr (d_wr), .d_addr (d_addr),
      .d_wdata (d_wdata), .d_grant (d_grant), .d_data_valid (d_data_valid),
      .rd_data (rd_data), .issue_rdy (issue_rdy),
      .mem_en (mem_en), .mem_wr (mem_wr), .mem_addr (mem_addr),
      .mem_wdata (mem_wdata), .mem_data (mem_data),
      .mem_data_valid (mem_data_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: who owns the port, reads in flight, last winner.
   int owner    = OWN_NONE;
   int inflight = 0;
   bit last_d   = 1'b0;
   int cyc      = 0;

   // Memory: due cycles of outstanding reads, plus stray-return rate.
   int ret_q[$];
   int last_due  = 0;
   int lat_min   = 10;
   int lat_max   = 10;
   int stray_pct = 0;

   // Random requesters: active flag and reads/writes left to issue.
   bit auto_mode = 1'b0;
   bit i_act = 1'b0, d_act = 1'b0;
   int i_left = 0, d_left = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic check_reset_outputs();
      check("rst_i_grant", 32'(i_grant), 32'd0);
      check("rst_d_grant", 32'(d_grant), 32'd0);
      check("rst_i_dv",    32'(i_data_valid), 32'd0);
      check("rst_d_dv",    32'(d_data_valid), 32'd0);
      check("rst_mem_en",  32'(mem_en), 32'd0);
      check("rst_mem_wr",  32'(mem_wr), 32'd0);
      check("rst_addr",    32'(mem_addr), 32'd0);
      check("rst_wdata",   32'(mem_wdata), 32'd0);
      check("rst_rdy",     32'(issue_rdy), 32'd1);
   endtask

   // One clock: present memory response, compare outputs, advance model.
   task automatic run_cycle();
      bit   due;
      logic gi, gd, rdy, pend, men, mwr, rd_iss, ret;
      logic [ADDR_W-1:0] eaddr;
      logic [DATA_W-1:0] ewdata;
      int   nown, d;
      due = (ret_q.size() > 0) && (ret_q[0] == cyc);
      if (due) void'(ret_q.pop_front());
      mem_data_valid = due || ($urandom_range(99) < stray_pct);
      mem_data       = DATA_W'($urandom);
      #1;
      gi     = (owner == OWN_IS);
      gd     = (owner == OWN_DS);
      rdy    = (inflight < MAX_OUT);
      pend   = (inflight > 0);
      men    = rdy && ((gi && i_en) || (gd && d_en));
      mwr    = gd && d_wr;
      eaddr  = gi ? i_addr : (gd ? d_addr : '0);
      ewdata = gd ? d_wdata : '0;
      check("i_grant",   32'(i_grant), 32'(gi));
      check("d_grant",   32'(d_grant), 32'(gd));
      check("issue_rdy", 32'(issue_rdy), 32'(rdy));
      check("mem_en",    32'(mem_en), 32'(men));
      check("mem_wr",    32'(mem_wr), 32'(mwr));
      check("mem_addr",  32'(mem_addr), 32'(eaddr));
      check("mem_wdata", 32'(mem_wdata), 32'(ewdata));
      check("i_dv",      32'(i_data_valid), 32'(mem_data_valid && pend && gi));
      check("d_dv",      32'(d_data_valid), 32'(mem_data_valid && pend && gd));
      check("rd_data",   32'(rd_data), 32'(mem_data));
      rd_iss = men && !mwr;
      ret    = mem_data_valid && pend;
      if (rd_iss) begin
         d = cyc + int'($urandom_range(lat_max, lat_min));
         if (d <= last_due) d = last_due + 1;
         last_due = d;
         ret_q.push_back(d);
      end
      if (auto_mode && men && gi) begin
         i_left--;
         if (i_left == 0) i_act = 1'b0;
      end
      if (auto_mode && men && gd) begin
         d_left--;
         if (d_left == 0) d_act = 1'b0;
      end
      nown = owner;
      if (owner == OWN_NONE) begin
         if (i_req && d_req) begin
`ifdef MEM_ARB_RR_EN
            nown = last_d ? OWN_IS : OWN_DS;
`else
            nown = OWN_DS;
`endif
         end else if (d_req) nown = OWN_DS;
         else if (i_req) nown = OWN_IS;
         if (nown != OWN_NONE) last_d = (nown == OWN_DS);
      end else if (owner == OWN_IS && !i_req && !pend) begin
         nown = OWN_NONE;
      end else if (owner == OWN_DS && !d_req && !pend) begin
         nown = OWN_NONE;
      end
      owner    = nown;
      inflight = inflight + (rd_iss ? 1 : 0) - (ret ? 1 : 0);
      cyc++;
      @(posedge clk);
      #1;
   endtask

   // Asynchronous reset in the middle of traffic, away from any edge.
   task automatic pulse_reset();
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      owner = OWN_NONE; inflight = 0; last_d = 1'b0;
      ret_q.delete(); last_due = cyc;
      i_act = 1'b0; d_act = 1'b0;
      i_req = 1'b0; d_req = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc++;
   endtask

   task automatic drain();
      for (int k = 0; k < 60 && owner != OWN_NONE; k++) run_cycle();
      check("drain_idle", 32'({i_grant, d_grant}), 32'd0);
   endtask

   initial begin
      int next_rst;
      rst_n = 1'b0;
      i_req = 0; i_en = 0; i_addr = '0;
      d_req = 0; d_en = 0; d_wr = 0; d_addr = '0; d_wdata = '0;
      mem_data = '0; mem_data_valid = 1'b0;
      #2;
      check_reset_outputs();
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;

      // Simultaneous requests from idle: D wins the first tie either way.
      i_req = 1; d_req = 1;
      run_cycle();
      check("tie_first", 32'({i_grant, d_grant}), 32'b01);

      // Write-through: same-cycle strobe, counter untouched.
      d_en = 1; d_wr = 1; d_addr = 16'h1234; d_wdata = 16'hBEEF;
      run_cycle();
      d_en = 0; d_wr = 0; d_req = 0; i_req = 0;
      run_cycle();
      check("wr_release", 32'({i_grant, d_grant, issue_rdy}), 32'b001);

      // Second tie decides between round-robin and fixed priority.
      i_req = 1; d_req = 1;
      run_cycle();
`ifdef MEM_ARB_RR_EN
      check("tie_second", 32'({i_grant, d_grant}), 32'b10);
`else
      check("tie_second", 32'({i_grant, d_grant}), 32'b01);
`endif
      i_req = 0; d_req = 0;
      drain();

      // D releases with two reads in flight while I waits.
      d_req = 1;
      run_cycle();
      d_en = 1; d_addr = 16'h0100;
      run_cycle();
      d_addr = 16'h0101;
      run_cycle();
      d_en = 0; d_req = 0; i_req = 1;
      for (int k = 0; k < 30 && owner != OWN_IS; k++) run_cycle();
      check("handoff_i", 32'({i_grant, d_grant}), 32'b10);

      // Six back-to-back I reads: the fifth and sixth are held off.
      i_en = 1;
      for (int k = 0; k < 6; k++) begin
         i_addr = ADDR_W'(k);
         run_cycle();
      end
      check("sat_rdy", 32'(issue_rdy), 32'd0);
      i_en = 0; i_req = 0;
      drain();

      // Random traffic with stray returns and mid-transaction resets.
      auto_mode = 1'b1; stray_pct = 3; lat_min = 2; lat_max = 8;
      next_rst = 1000;
      for (int n = 0; n < 3000; n++) begin
         if (cyc >= next_rst && owner != OWN_NONE && inflight > 0) begin
            pulse_reset();
            next_rst = cyc + 900;
         end
         if (!i_act && $urandom_range(99) < 20) begin
            i_act = 1'b1; i_left = int'($urandom_range(8, 1));
         end
         if (!d_act && $urandom_range(99) < 20) begin
            d_act = 1'b1; d_left = int'($urandom_range(8, 1));
         end
         i_req   = i_act;
         i_en    = ($urandom_range(99) < 70);
         i_addr  = ADDR_W'($urandom);
         d_req   = d_act;
         d_en    = ($urandom_range(99) < 70);
         d_wr    = ($urandom_range(99) < 30);
         d_addr  = ADDR_W'($urandom);
         d_wdata = DATA_W'($urandom);
         run_cycle();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
